// File: rtl/argument_pop_scheduler.sv
// ---------------------------------------------------------------------------
// argument_pop_scheduler
//   Lets NUM_REQ field parsers share one argument_decoder output. A round-robin
//   arbiter grants one request per ISSUE cycle. The low req_len bits of dec_q
//   are returned to the winner, and dec_pop tells the decoder how many bits to
//   shift out. Each ISSUE cycle is followed by a SETTLE cycle, which gives the
//   decoder time to update q/ready, so at most one field is issued every two
//   cycles.
//
// Optional feature: define ARG_SCHED_STALL_CNT_EN to add the stall_cnt output.
//
// Ports
//   clk        clock, rising edge
//   rst        synchronous active-high reset
//   req        per-requester request, held until gnt
//   req_len    per-requester field length, requester i at [i*L +: L]
//   gnt        one-hot acceptance pulse (ISSUE cycle only)
//   rsp_vld    field valid pulse, one cycle after gnt
//   rsp_id     index of the requester that owns rsp_data
//   rsp_data   zero-extended field, LSB aligned
//   dec_q      decoder output, next bits at the LSB
//   dec_ready  decoder has valid data
//   dec_pop    number of bits the decoder consumes (0 = none)
//   stall_cnt  (optional) saturating count of cycles with |req && !dec_ready
// ---------------------------------------------------------------------------
module argument_pop_scheduler #(
    parameter int unsigned NUM_REQ        = 4,
    parameter int unsigned LOG2_NUM_REQ   = 2,
    parameter int unsigned WIDTH_OUT      = 64,
    parameter int unsigned LOG2_WIDTH_OUT = 6
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic [NUM_REQ-1:0]                req,
    input  logic [NUM_REQ*LOG2_WIDTH_OUT-1:0] req_len,
    output logic [NUM_REQ-1:0]                gnt,
    output logic                              rsp_vld,
    output logic [LOG2_NUM_REQ-1:0]           rsp_id,
    output logic [WIDTH_OUT-1:0]              rsp_data,
    input  logic [WIDTH_OUT-1:0]              dec_q,
    input  logic                              dec_ready,
    output logic [LOG2_WIDTH_OUT-1:0]         dec_pop
`ifdef ARG_SCHED_STALL_CNT_EN
    ,
    output logic [31:0]                       stall_cnt
`endif
);

    typedef enum logic [1:0] {
        StIdle   = 2'd0,
        StIssue  = 2'd1,
        StSettle = 2'd2
    } state_e;

    localparam logic [WIDTH_OUT:0] MaskOne = {{WIDTH_OUT{1'b0}}, 1'b1};

    state_e                    state_q, state_d;
    logic [LOG2_NUM_REQ-1:0]   rr_ptr_q, rr_ptr_d;
    logic [LOG2_NUM_REQ-1:0]   win;
    logic [LOG2_NUM_REQ-1:0]   idx;
    logic                      found;
    logic [LOG2_WIDTH_OUT-1:0] win_len;
    logic [WIDTH_OUT:0]        mask;
    logic                      issue;

    // Round-robin search starting at rr_ptr and wrapping modulo NUM_REQ.
    always_comb begin
        win   = '0;
        idx   = '0;
        found = 1'b0;
        for (int unsigned k = 0; k < NUM_REQ; k++) begin
            idx = LOG2_NUM_REQ'((32'(rr_ptr_q) + k) % NUM_REQ);
            if (!found && req[idx]) begin
                found = 1'b1;
                win   = idx;
            end
        end
    end

    assign win_len = req_len[win*LOG2_WIDTH_OUT +: LOG2_WIDTH_OUT];
    // Computed one bit wider than the data so that the shift cannot overflow.
    assign mask    = (MaskOne << win_len) - MaskOne;

    always_comb begin
        state_d  = state_q;
        rr_ptr_d = rr_ptr_q;
        gnt      = '0;
        dec_pop  = '0;
        issue    = 1'b0;
        case (state_q)
            StIdle: begin
                if (found && dec_ready) state_d = StIssue;
            end
            StIssue: begin
                // Requests and readiness are checked again here. If either has
                // dropped, return to IDLE without granting or popping.
                if (found && dec_ready) begin
                    issue    = 1'b1;
                    gnt[win] = 1'b1;
                    dec_pop  = win_len;
                    rr_ptr_d = (32'(win) == NUM_REQ - 1) ? '0 : win + LOG2_NUM_REQ'(1);
                    state_d  = StSettle;
                end else begin
                    state_d = StIdle;
                end
            end
            StSettle: begin
                state_d = (found && dec_ready) ? StIssue : StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= StIdle;
            rr_ptr_q <= '0;
            rsp_vld  <= 1'b0;
            rsp_id   <= '0;
            rsp_data <= '0;
        end else begin
            state_q  <= state_d;
            rr_ptr_q <= rr_ptr_d;
            rsp_vld  <= issue;
            if (issue) begin
                rsp_id   <= win;
                rsp_data <= dec_q & mask[WIDTH_OUT-1:0];
            end
        end
    end

`ifdef ARG_SCHED_STALL_CNT_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cnt <= '0;
        end else if (|req && !dec_ready && (stall_cnt != 32'hFFFF_FFFF)) begin
            stall_cnt <= stall_cnt + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_argument_pop_scheduler.sv
module tb_argument_pop_scheduler;

    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  req;
    logic [5:0]  lens [4];
    logic [23:0] req_len;
    logic [3:0]  gnt;
    logic        rsp_vld;
    logic [1:0]  rsp_id;
    logic [63:0] rsp_data;
    logic [63:0] dec_q;
    logic        dec_ready;
    logic [5:0]  dec_pop;
`ifdef ARG_SCHED_STALL_CNT_EN
    logic [31:0] stall_cnt;
    logic [31:0] stall0;
`endif

    int checks = 0;
    int errors = 0;

    logic [65:0] sb_q [$];
    logic [3:0]  prev_gnt = '0;
    logic        edge_rst = 1'b1;
    logic        mon_en   = 1'b0;
    int          n;

    assign req_len = {lens[3], lens[2], lens[1], lens[0]};

    always #5 clk = ~clk;

    argument_pop_scheduler dut (
        .clk       (clk),
        .rst       (rst),
        .req       (req),
        .req_len   (req_len),
        .gnt       (gnt),
        .rsp_vld   (rsp_vld),
        .rsp_id    (rsp_id),
        .rsp_data  (rsp_data),
        .dec_q     (dec_q),
        .dec_ready (dec_ready),
        .dec_pop   (dec_pop)
`ifdef ARG_SCHED_STALL_CNT_EN
        ,
        .stall_cnt (stall_cnt)
`endif
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    function automatic logic [63:0] field(input logic [63:0] q, input int len);
        logic [63:0] r = '0;
        for (int i = 0; i < len; i++) r[i] = q[i];
        return r;
    endfunction

    function automatic int idx_of(input logic [3:0] v);
        for (int i = 0; i < 4; i++) if (v[i]) return i;
        return 0;
    endfunction

    task automatic push_exp(input int id);
        sb_q.push_back({2'(id), field(dec_q, int'(lens[id]))});
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Returns at the negedge where gnt is seen; cnt counts the negedges waited.
    task automatic wait_gnt(input string tag, input logic [3:0] exp, output int cnt);
        cnt = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            cnt++;
            if (gnt != 0) break;
        end
        check(tag, gnt, exp);
    endtask

    always @(posedge clk) edge_rst <= rst;

    // Response scoreboard plus grant and pop protocol checks.
    always @(negedge clk) begin
        if (mon_en) begin
            logic [65:0] e;
            check("rsp_vld_timing", rsp_vld, (prev_gnt != 0) && !edge_rst);
            if (rsp_vld) begin
                if (sb_q.size() == 0) begin
                    check("rsp_unexpected", 1, 0);
                end else begin
                    e = sb_q.pop_front();
                    check("rsp_id", rsp_id, e[65:64]);
                    check("rsp_data", rsp_data, e[63:0]);
                end
            end
            if (gnt != 0) begin
                check("gnt_onehot", $onehot(gnt), 1);
                check("gnt_in_req", gnt & ~req, 0);
                check("gnt_spacing", prev_gnt, 0);
                check("dec_pop_len", dec_pop, lens[idx_of(gnt)]);
            end else begin
                check("dec_pop_idle", dec_pop, 0);
            end
            prev_gnt = gnt;
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

    initial begin
        rst       = 1'b1;
        req       = 4'b1111;
        dec_ready = 1'b1;
        dec_q     = 64'h0123_4567_89AB_CDEF;
        lens[0]   = 6'd3;
        lens[1]   = 6'd7;
        lens[2]   = 6'd12;
        lens[3]   = 6'd20;
        step();
        mon_en = 1'b1;

        // Reset held with every requester active.
        repeat (3) begin
            @(negedge clk);
            check("rst_gnt", gnt, 0);
            check("rst_rsp_vld", rsp_vld, 0);
            check("rst_dec_pop", dec_pop, 0);
            step();
        end
        rst = 1'b0;

        // All requesters held: strict rotation starting at index 0.
        for (int i = 0; i < 5; i++) push_exp(i % 4);
        for (int i = 0; i < 5; i++) begin
            wait_gnt("rr_order", 4'b0001 << (i % 4), n);
        end
        step();
        req = 4'b0000;
        repeat (3) step();

        // Single request, field sliced from dec_q.
        dec_q   = 64'hFF;
        lens[2] = 6'd5;
        req     = 4'b0100;
        push_exp(2);
        wait_gnt("single_gnt", 4'b0100, n);
        check("single_pop", dec_pop, 5);
        step();
        req = 4'b0000;
        @(negedge clk);
        check("single_vld", rsp_vld, 1);
        check("single_id", rsp_id, 2);
        check("single_data", rsp_data, 64'h1F);
        repeat (3) step();

        // Decoder stalled for 10 cycles.
        dec_q     = 64'hDEAD_BEEF_CAFE_F00D;
        lens[0]   = 6'd9;
        req       = 4'b0001;
        dec_ready = 1'b0;
`ifdef ARG_SCHED_STALL_CNT_EN
        stall0    = stall_cnt;
`endif
        push_exp(0);
        repeat (10) begin
            @(negedge clk);
            check("stall_no_gnt", gnt, 0);
            step();
        end
        dec_ready = 1'b1;
        wait_gnt("stall_gnt", 4'b0001, n);
        check("stall_latency", n, 2);
        step();
        req = 4'b0000;
`ifdef ARG_SCHED_STALL_CNT_EN
        check("stall_cnt", stall_cnt - stall0, 10);
`endif
        repeat (3) step();

        // Boundary lengths: 0 and WIDTH_OUT-1.
        dec_q   = '1;
        lens[1] = 6'd0;
        lens[3] = 6'd63;
        req     = 4'b1010;
        push_exp(1);
        push_exp(3);
        wait_gnt("len0_gnt", 4'b0010, n);
        check("len0_pop", dec_pop, 0);
        step();
        req = 4'b1000;
        wait_gnt("len63_gnt", 4'b1000, n);
        check("len63_pop", dec_pop, 63);
        step();
        req = 4'b0000;
        @(negedge clk);
        check("len63_data", rsp_data, 64'h7FFF_FFFF_FFFF_FFFF);
        repeat (3) step();

        // Move the pointer to 2, then reset during an ISSUE cycle.
        dec_q   = 64'hA5;
        lens[1] = 6'd4;
        lens[2] = 6'd6;
        req     = 4'b0010;
        push_exp(1);
        wait_gnt("pre_rst_gnt", 4'b0010, n);
        step();
        req = 4'b0000;
        repeat (2) step();
        req = 4'b1110;
        wait_gnt("issue_before_rst", 4'b0100, n);
        #2;
        rst = 1'b1;
        step();
        @(negedge clk);
        check("rst_drop_vld", rsp_vld, 0);
        check("rst_drop_gnt", gnt, 0);
        step();
        rst = 1'b0;
        push_exp(1);
        wait_gnt("post_rst_lowest", 4'b0010, n);
        step();
        req = 4'b0000;
        repeat (4) step();

        check("sb_empty", sb_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
